// File: rtl/count_run_arbiter.sv
// count_run_arbiter: shares one up-counter among NREQ requesters.
// Requesters are served round-robin. The granted requester gets a run of
// len_q counts on cout (1..len_q), then a one-cycle done pulse, then a
// mandatory idle cycle before the next arbitration.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no run active; arbitrate among req starting at rr_ptr
// RUN    | counter stepping 1..len_q for the granted owner
// DONE   | one-cycle completion pulse on done[owner]
module count_run_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 3,
  parameter int OW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   len,
  input  logic                 abort,
  output logic [NREQ-1:0]      gnt,
  output logic [OW-1:0]        owner,
  output logic                 busy,
  output logic                 cnt_valid,
  output logic [CW-1:0]        cout,
  output logic [NREQ-1:0]      done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   len_q, len_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            cnt_valid_q, cnt_valid_d;
  logic [CW-1:0]   cout_q, cout_d;
  logic [NREQ-1:0] done_q, done_d;

  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic [CW-1:0]   win_len;
  logic [OW-1:0]   owner_inc;
  int              scan_idx;

  // Round-robin scan: first active request at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int off = 0; off < NREQ; off++) begin
      scan_idx = int'(rr_ptr_q) + off;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = OW'(scan_idx);
      end
    end
  end

  // Winner's length field; zero-length requests are treated as length 1.
  always_comb begin
    win_len = len[int'(win_idx)*CW +: CW];
    if (win_len == '0) begin
      win_len = CW'(1);
    end
  end

  // Pointer value that skips past the current owner (wraps NREQ-1 -> 0).
  always_comb begin
    if (owner_q == OW'(NREQ-1)) begin
      owner_inc = '0;
    end else begin
      owner_inc = owner_q + 1'b1;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    len_d       = len_q;
    gnt_d       = '0;
    owner_d     = '0;
    busy_d      = 1'b0;
    cnt_valid_d = 1'b0;
    cout_d      = '0;
    done_d      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d          = S_RUN;
          len_d            = win_len;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          busy_d           = 1'b1;
          cnt_valid_d      = 1'b1;
          cout_d           = CW'(1);
        end
      end

      S_RUN: begin
        if (abort) begin
          // Aborted client forfeits its turn; no completion pulse.
          state_d  = S_IDLE;
          rr_ptr_d = owner_inc;
        end else if (cout_q == len_q) begin
          state_d          = S_DONE;
          rr_ptr_d         = owner_inc;
          owner_d          = owner_q;
          busy_d           = 1'b1;
          done_d[owner_q]  = 1'b1;
        end else begin
          gnt_d       = gnt_q;
          owner_d     = owner_q;
          busy_d      = 1'b1;
          cnt_valid_d = 1'b1;
          cout_d      = cout_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      len_q       <= '0;
      gnt_q       <= '0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      cnt_valid_q <= 1'b0;
      cout_q      <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      len_q       <= len_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      cnt_valid_q <= cnt_valid_d;
      cout_q      <= cout_d;
      done_q      <= done_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign cnt_valid = cnt_valid_q;
  assign cout      = cout_q;
  assign done      = done_q;

endmodule

// File: tb/tb_count_run_arbiter.sv
// Directed bench for count_run_arbiter (NREQ=4, CW=3).
module tb_count_run_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 3;
  localparam int OW   = 2;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*CW-1:0]   len;
  logic                 abort;
  logic [NREQ-1:0]      gnt;
  logic [OW-1:0]        owner;
  logic                 busy;
  logic                 cnt_valid;
  logic [CW-1:0]        cout;
  logic [NREQ-1:0]      done;

  int n_total = 0;
  int n_bad   = 0;

  count_run_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .len       (len),
    .abort     (abort),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .cnt_valid (cnt_valid),
    .cout      (cout),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] o,
                            input logic b, input logic cv, input logic [2:0] c,
                            input logic [3:0] d);
    chk({tag, ".gnt"},   32'(gnt),       32'(g));
    chk({tag, ".owner"}, 32'(owner),     32'(o));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".cv"},    32'(cnt_valid), 32'(cv));
    chk({tag, ".cout"},  32'(cout),      32'(c));
    chk({tag, ".done"},  32'(done),      32'(d));
  endtask

  task automatic set_len(input int idx, input logic [2:0] v);
    len[idx*CW +: CW] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One full run starting from IDLE with req already presented:
  // L RUN cycles, one DONE cycle, one IDLE cycle.
  task automatic run_chk(input string tag, input int idx, input int l);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    for (int c = 1; c <= l; c++) begin
      tick();
      check_outs({tag, ".run"}, oh, 2'(idx), 1'b1, 1'b1, 3'(c), 4'b0000);
    end
    tick();
    check_outs({tag, ".done"}, 4'b0000, 2'(idx), 1'b1, 1'b0, 3'd0, oh);
    tick();
    check_outs({tag, ".idle"}, 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0, 4'b0000);
  endtask

  // Structural invariants, sampled away from the active edge.
  always @(negedge clk) begin
    chk("inv_gnt_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("inv_cv_gnt", 32'(cnt_valid), 32'(|gnt));
    chk("inv_done_onehot", 32'($onehot0(done)), 32'd1);
    chk("inv_cout_live", 32'(cout != '0), 32'(cnt_valid));
    if (done != '0) begin
      chk("inv_done_phase", {29'd0, busy, |gnt, cnt_valid}, 32'b100);
    end
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    len   = '0;
    abort = 1'b0;

    // Reset and idle with no requests
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs("idle", 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0, 4'b0000);
    end

    // Reset in the middle of a run
    set_len(0, 3'd5);
    req = 4'b0001;
    tick();
    check_outs("mr.c1", 4'b0001, 2'd0, 1'b1, 1'b1, 3'd1, 4'b0000);
    tick();
    check_outs("mr.c2", 4'b0001, 2'd0, 1'b1, 1'b1, 3'd2, 4'b0000);
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    check_outs("mr.rst", 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0, 4'b0000);
    reset = 1'b0;
    tick();
    check_outs("mr.after", 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0, 4'b0000);

    // Single run of 3; req and len changes during RUN are ignored
    set_len(0, 3'd3);
    req = 4'b0001;
    tick();
    check_outs("s3.c1", 4'b0001, 2'd0, 1'b1, 1'b1, 3'd1, 4'b0000);
    req = 4'b0000;
    set_len(0, 3'd7);
    tick();
    check_outs("s3.c2", 4'b0001, 2'd0, 1'b1, 1'b1, 3'd2, 4'b0000);
    tick();
    check_outs("s3.c3", 4'b0001, 2'd0, 1'b1, 1'b1, 3'd3, 4'b0000);
    tick();
    check_outs("s3.done", 4'b0000, 2'd0, 1'b1, 1'b0, 3'd0, 4'b0001);
    tick();
    check_outs("s3.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0, 4'b0000);

    // Two requesters alternate: 0, 2, 0, 2
    do_reset();
    set_len(0, 3'd2);
    set_len(2, 3'd4);
    req = 4'b0101;
    run_chk("alt0a", 0, 2);
    run_chk("alt2a", 2, 4);
    run_chk("alt0b", 0, 2);
    run_chk("alt2b", 2, 4);
    req = 4'b0000;

    // All four requesting, full-length runs, pointer wraps
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 3'd7);
    req = 4'b1111;
    run_chk("rot0", 0, 7);
    run_chk("rot1", 1, 7);
    run_chk("rot2", 2, 7);
    run_chk("rot3", 3, 7);
    run_chk("rot0w", 0, 7);
    req = 4'b0000;

    // Abort mid-run; aborted client loses its turn
    do_reset();
    set_len(1, 3'd6);
    req = 4'b0010;
    tick();
    check_outs("ab.c1", 4'b0010, 2'd1, 1'b1, 1'b1, 3'd1, 4'b0000);
    tick();
    check_outs("ab.c2", 4'b0010, 2'd1, 1'b1, 1'b1, 3'd2, 4'b0000);
    tick();
    check_outs("ab.c3", 4'b0010, 2'd1, 1'b1, 1'b1, 3'd3, 4'b0000);
    abort = 1'b1;
    tick();
    check_outs("ab.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0, 4'b0000);
    abort = 1'b0;
    set_len(0, 3'd2);
    req = 4'b0011;
    run_chk("ab.next0", 0, 2);
    req = 4'b0000;

    // Zero length clamps to a one-count run
    do_reset();
    set_len(0, 3'd0);
    req = 4'b0001;
    run_chk("zl", 0, 1);
    req = 4'b0000;

    // Abort coinciding with terminal count: no done
    set_len(0, 3'd2);
    req = 4'b0001;
    tick();
    check_outs("at.c1", 4'b0001, 2'd0, 1'b1, 1'b1, 3'd1, 4'b0000);
    tick();
    check_outs("at.c2", 4'b0001, 2'd0, 1'b1, 1'b1, 3'd2, 4'b0000);
    abort = 1'b1;
    tick();
    check_outs("at.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0, 4'b0000);

    // Abort held in IDLE does not block a grant, then kills the run
    tick();
    check_outs("ai.grant", 4'b0001, 2'd0, 1'b1, 1'b1, 3'd1, 4'b0000);
    tick();
    check_outs("ai.kill", 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0, 4'b0000);
    abort = 1'b0;
    req   = 4'b0000;
    tick();
    check_outs("ai.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
